ibus_fetch: RTL and testbench

- Fetch-side initiator of the instruction bus. Owns the fetch PC, issues one `ibus_req_t` at a time, and tracks the `addr_ok`/`data_ok` handshake.
- Presents each returned instruction, with its PC, as an `ibus_resp_t` plus `addr_t` pair. That pair is exactly the input shape of the pre-decode stage.
- Handles downstream stall with a one-entry response buffer, and handles branch/jump redirect by squashing the in-flight fetch.

---
 rtl/ibus_fetch_pkg.sv | 30 +++
 rtl/fetch_skid_buf.sv | 63 ++++++
 rtl/ibus_fetch.sv | 152 +++++++++++++++
 tb/tb_ibus_fetch.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ibus_fetch_pkg.sv
// Shared instruction-bus types and fetch-stage constants.
package ibus_fetch_pkg;

    typedef logic [31:0] addr_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam addr_t RESET_PC_DEFAULT = 32'hbfc0_0000;
    localparam addr_t PC_STEP          = 32'd4;

    function automatic addr_t next_seq_pc(input addr_t pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched {data, pc} while downstream stalls.
module fetch_skid_buf
    import ibus_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cand_valid,
    input  logic [31:0] cand_data,
    input  addr_t       cand_pc,
    input  logic        stall,
    input  logic        flush,
    output logic        sel_valid,
    output logic [31:0] sel_data,
    output addr_t       sel_pc,
    output logic        held
);

    logic        buf_valid_r;
    logic [31:0] buf_data_r;
    addr_t       buf_pc_r;

    // Capture an unconsumed instruction; release it once downstream accepts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid_r <= 1'b0;
            buf_data_r  <= 32'd0;
            buf_pc_r    <= 32'd0;
        end else if (flush) begin
            buf_valid_r <= 1'b0;
        end else if (buf_valid_r) begin
            if (!stall) begin
                buf_valid_r <= 1'b0;
            end
        end else if (cand_valid && stall) begin
            buf_valid_r <= 1'b1;
            buf_data_r  <= cand_data;
            buf_pc_r    <= cand_pc;
        end
    end

    // Buffered entry has priority over a fresh completion.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = 32'd0;
        sel_pc    = 32'd0;
        if (buf_valid_r) begin
            sel_valid = 1'b1;
            sel_data  = buf_data_r;
            sel_pc    = buf_pc_r;
        end else if (cand_valid) begin
            sel_valid = 1'b1;
            sel_data  = cand_data;
            sel_pc    = cand_pc;
        end else begin
            sel_valid = 1'b0;
            sel_data  = 32'd0;
            sel_pc    = 32'd0;
        end
    end

    assign held = buf_valid_r;

endmodule

// File: rtl/ibus_fetch.sv
// Instruction-bus fetch initiator: owns the PC, one outstanding request,
// redirect squash and a one-entry stall buffer toward pre-decode.
module ibus_fetch
    import ibus_fetch_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    output ibus_req_t  ireq,
    input  ibus_resp_t iresp,
    input  logic       stall,
    input  logic       redirect_valid,
    input  addr_t      redirect_pc,
    output ibus_resp_t out_resp,
    output addr_t      out_pc
);

    fetch_state_t state_r, state_nxt_s;
    addr_t        pc_r, pc_nxt_s;
    addr_t        req_pc_r, req_pc_nxt_s;
    addr_t        pend_pc_r, pend_pc_nxt_s;
    logic         discard_r, discard_nxt_s;
    logic         pend_valid_r, pend_valid_nxt_s;

    logic         issue_s, accept_s, complete_s, deliver_s, in_flight_s;
    addr_t        comp_pc_s, after_comp_pc_s;
    logic         sel_valid_s, held_s;
    logic [31:0]  sel_data_s;
    addr_t        sel_pc_s;

    // Requests are gated by reset so nothing is presented while it is held.
    assign issue_s         = (state_r == REQ) && !reset;
    assign accept_s        = issue_s && iresp.addr_ok;
    assign complete_s      = (accept_s && iresp.data_ok) ||
                             ((state_r == WAIT) && iresp.data_ok && !reset);
    assign in_flight_s     = issue_s || (state_r == WAIT);
    assign comp_pc_s       = (state_r == REQ) ? pc_r : req_pc_r;
    assign deliver_s       = complete_s && !discard_r && !redirect_valid;
    assign after_comp_pc_s = pend_valid_r ? pend_pc_r : next_seq_pc(comp_pc_s);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= REQ;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: a delivered instruction under stall parks the FSM in HOLD.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            REQ: begin
                if (accept_s && !iresp.data_ok) begin
                    state_nxt_s = WAIT;
                end else if (deliver_s && stall) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                if (complete_s) begin
                    state_nxt_s = (deliver_s && stall) ? HOLD : REQ;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            HOLD: begin
                if (!stall || redirect_valid) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = REQ;
        endcase
    end

    // PC / redirect bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r         <= RESET_PC;
            req_pc_r     <= 32'd0;
            pend_pc_r    <= 32'd0;
            discard_r    <= 1'b0;
            pend_valid_r <= 1'b0;
        end else begin
            pc_r         <= pc_nxt_s;
            req_pc_r     <= req_pc_nxt_s;
            pend_pc_r    <= pend_pc_nxt_s;
            discard_r    <= discard_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
        end
    end

    // A redirect with a request in flight is deferred; otherwise it loads pc now.
    always_comb begin
        pc_nxt_s         = pc_r;
        req_pc_nxt_s     = req_pc_r;
        pend_pc_nxt_s    = pend_pc_r;
        discard_nxt_s    = discard_r;
        pend_valid_nxt_s = pend_valid_r;
        if (complete_s) begin
            discard_nxt_s    = 1'b0;
            pend_valid_nxt_s = 1'b0;
            pc_nxt_s         = redirect_valid ? redirect_pc : after_comp_pc_s;
        end else if (redirect_valid) begin
            if (in_flight_s) begin
                discard_nxt_s    = 1'b1;
                pend_valid_nxt_s = 1'b1;
                pend_pc_nxt_s    = redirect_pc;
            end else begin
                pc_nxt_s = redirect_pc;
            end
        end else begin
            pc_nxt_s = pc_r;
        end
        if (accept_s && !iresp.data_ok) begin
            req_pc_nxt_s = pc_r;
        end else begin
            req_pc_nxt_s = req_pc_nxt_s;
        end
    end

    fetch_skid_buf u_skid (
        .clk        (clk),
        .reset      (reset),
        .cand_valid (deliver_s),
        .cand_data  (iresp.data),
        .cand_pc    (comp_pc_s),
        .stall      (stall),
        .flush      (redirect_valid),
        .sel_valid  (sel_valid_s),
        .sel_data   (sel_data_s),
        .sel_pc     (sel_pc_s),
        .held       (held_s)
    );

    // Output drive toward the bus and pre-decode.
    always_comb begin
        ireq.valid       = issue_s && !held_s;
        ireq.addr        = issue_s ? pc_r : 32'd0;
        out_resp.addr_ok = 1'b0;
        out_resp.data_ok = sel_valid_s;
        out_resp.data    = sel_data_s;
        out_pc           = sel_pc_s;
    end

endmodule

// File: tb/tb_ibus_fetch.sv
// Directed vector bench for ibus_fetch: per-cycle bus/stall/redirect inputs
// with hand-computed request and output expectations.
module tb_ibus_fetch;
    import ibus_fetch_pkg::*;

    typedef struct packed {
        logic        st;
        logic        rv;
        addr_t       rpc;
        logic        aok;
        logic        dok;
        logic [31:0] d;
        logic        e_valid;
        addr_t       e_addr;
        logic        e_dok;
        addr_t       e_pc;
        logic [31:0] e_data;
    } vec_t;

    localparam int NV = 29;

    logic       clk = 1'b0;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    logic       stall;
    logic       redirect_valid;
    addr_t      redirect_pc;
    ibus_resp_t out_resp;
    addr_t      out_pc;

    int   vectors     = 0;
    int   miscompares = 0;
    vec_t vt [NV];

    always #5 clk = ~clk;

    ibus_fetch #(.RESET_PC(RESET_PC_DEFAULT)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_resp       (out_resp),
        .out_pc         (out_pc)
    );

    function automatic vec_t mk(input logic st, input logic rv, input addr_t rpc,
                                input logic aok, input logic dok, input logic [31:0] d,
                                input logic ev, input addr_t ea, input logic ed,
                                input addr_t ep, input logic [31:0] edat);
        vec_t v;
        v.st = st; v.rv = rv; v.rpc = rpc; v.aok = aok; v.dok = dok; v.d = d;
        v.e_valid = ev; v.e_addr = ea; v.e_dok = ed; v.e_pc = ep; v.e_data = edat;
        return v;
    endfunction

    task automatic cmp(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rv, input addr_t rpc,
                         input logic aok, input logic dok, input logic [31:0] d);
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        iresp.addr_ok  = aok;
        iresp.data_ok  = dok;
        iresp.data     = d;
    endtask

    task automatic check_outputs(input int idx, input logic ev, input addr_t ea,
                                 input logic ed, input addr_t ep, input logic [31:0] edat);
        vectors++;
        cmp("ireq_valid", idx, 32'(ireq.valid), 32'(ev));
        if (ev) cmp("ireq_addr", idx, ireq.addr, ea);
        cmp("out_data_ok", idx, 32'(out_resp.data_ok), 32'(ed));
        cmp("out_addr_ok", idx, 32'(out_resp.addr_ok), 32'd0);
        if (ed) begin
            cmp("out_pc", idx, out_pc, ep);
            cmp("out_data", idx, out_resp.data, edat);
        end
    endtask

    initial begin
        // zero-latency bus, data = pc
        vt[0]  = mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hbfc00000, 1'b1, 32'hbfc00000, 1'b1, 32'hbfc00000, 32'hbfc00000);
        vt[1]  = mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hbfc00004, 1'b1, 32'hbfc00004, 1'b1, 32'hbfc00004, 32'hbfc00004);
        vt[2]  = mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hbfc00008, 1'b1, 32'hbfc00008, 1'b1, 32'hbfc00008, 32'hbfc00008);
        // latency-3: addr_ok after one cycle, data_ok two later
        vt[3]  = mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hbfc0000c, 1'b0, 32'd0, 32'd0);
        vt[4]  = mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 32'hbfc0000c, 1'b0, 32'd0, 32'd0);
        vt[5]  = mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        vt[6]  = mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h1111000c, 1'b0, 32'd0, 1'b1, 32'hbfc0000c, 32'h1111000c);
        // stall three cycles as 0x24020005 returns
        vt[7]  = mk(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h24020005, 1'b1, 32'hbfc00010, 1'b1, 32'hbfc00010, 32'h24020005);
        vt[8]  = mk(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hbfc00010, 32'h24020005);
        vt[9]  = mk(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hbfc00010, 32'h24020005);
        vt[10] = mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hbfc00010, 32'h24020005);
        // redirect in REQ before addr_ok: address held, data discarded
        vt[11] = mk(1'b0, 1'b1, 32'hbfc00100, 1'b0, 1'b0, 32'd0, 1'b1, 32'hbfc00014, 1'b0, 32'd0, 32'd0);
        vt[12] = mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hbfc00014, 1'b0, 32'd0, 32'd0);
        vt[13] = mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 32'hbfc00014, 1'b0, 32'd0, 32'd0);
        vt[14] = mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hdeadbeef, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        vt[15] = mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hbfc00100, 1'b1, 32'hbfc00100, 1'b1, 32'hbfc00100, 32'hbfc00100);
        // redirect during WAIT
        vt[16] = mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 32'hbfc00104, 1'b0, 32'd0, 32'd0);
        vt[17] = mk(1'b0, 1'b1, 32'hbfc00200, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        vt[18] = mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hcafef00d, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        vt[19] = mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hbfc00200, 1'b1, 32'hbfc00200, 1'b1, 32'hbfc00200, 32'hbfc00200);
        // redirect coinciding with data_ok
        vt[20] = mk(1'b0, 1'b1, 32'hbfc00300, 1'b1, 1'b1, 32'hbfc00204, 1'b1, 32'hbfc00204, 1'b0, 32'd0, 32'd0);
        vt[21] = mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hbfc00300, 1'b1, 32'hbfc00300, 1'b1, 32'hbfc00300, 32'hbfc00300);
        // redirect while holding a buffered instruction
        vt[22] = mk(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'hbfc00304, 1'b1, 32'hbfc00304, 1'b1, 32'hbfc00304, 32'hbfc00304);
        vt[23] = mk(1'b1, 1'b1, 32'hbfc00400, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hbfc00304, 32'hbfc00304);
        vt[24] = mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hbfc00400, 1'b1, 32'hbfc00400, 1'b1, 32'hbfc00400, 32'hbfc00400);
        // pc wrap past 2^32
        vt[25] = mk(1'b0, 1'b1, 32'hfffffffc, 1'b1, 1'b1, 32'hbfc00404, 1'b1, 32'hbfc00404, 1'b0, 32'd0, 32'd0);
        vt[26] = mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0badc0de, 1'b1, 32'hfffffffc, 1'b1, 32'hfffffffc, 32'h0badc0de);
        vt[27] = mk(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h00000000, 1'b0, 32'd0, 32'd0);
        vt[28] = mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h00000000, 1'b0, 32'd0, 32'd0);

        // reset held with an eager bus: nothing may be requested or delivered
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h12345678);
        @(posedge clk);
        @(negedge clk);
        #2;
        check_outputs(-1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        cmp("rst_out_pc", -1, out_pc, 32'd0);
        cmp("rst_out_data", -1, out_resp.data, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vt[i].st, vt[i].rv, vt[i].rpc, vt[i].aok, vt[i].dok, vt[i].d);
            #2;
            check_outputs(i, vt[i].e_valid, vt[i].e_addr, vt[i].e_dok, vt[i].e_pc, vt[i].e_data);
        end

        // async reset while WAIT and data_ok arrive together
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h55aa55aa);
        reset = 1'b1;
        #2;
        check_outputs(100, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        cmp("midrst_out_pc", 100, out_pc, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        #2;
        check_outputs(101, 1'b1, 32'hbfc00000, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h00000001);
        #2;
        check_outputs(102, 1'b1, 32'hbfc00000, 1'b1, 32'hbfc00000, 32'h00000001);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        #2;
        check_outputs(103, 1'b1, 32'hbfc00004, 1'b0, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
